bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the width of each parallel word; legal values are 2..32.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the word counter.
REQ-003 SHALL have port clk, input, width 1: the single clock, with all state on its rising edge.
REQ-004 SHALL have port reset, input, width 1: asynchronous, active-low reset.
REQ-005 SHALL have port data_in, input, width DATA_W: the parallel word, sampled only on handshake.
REQ-006 SHALL have port data_valid, input, width 1: the upstream word-present strobe.
REQ-007 SHALL have port data_ready, output, width 1: high when the block accepts a word this cycle.
REQ-008 SHALL have port msb_first, input, width 1: the bit order, sampled with data_in at handshake (1 = MSB first).
REQ-009 SHALL have port soft_clr, input, width 1: synchronous abort of the word in flight.
REQ-010 SHALL have port out_bit, output, width 1: the serial bit driving the downstream detector's inp_bit.
REQ-011 SHALL have port out_valid, output, width 1: high while out_bit carries a payload or parity bit.
REQ-012 SHALL have port word_cnt, output, width CNT_W: the count of words fully shifted out.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and PARITY; PARITY exists only when SER_PARITY_EN is defined.
REQ-014 SHALL define a handshake as data_valid && data_ready at a rising clk edge; data_in and msb_first are captured only then.
REQ-015 SHALL drive data_ready combinationally: high in IDLE, high in the final cycle of a word (last payload bit, or the PARITY cycle when enabled), otherwise low, and low while soft_clr is high.
REQ-016 SHALL register out_bit and out_valid, so the first bit of an accepted word appears in the cycle immediately after the handshake edge (latency 1).
REQ-017 SHALL emit exactly one bit per clk with no stall: DATA_W payload bits, plus one parity bit when enabled.
REQ-018 SHALL chain words with zero idle cycles when a handshake occurs in the final cycle of a word.
REQ-019 SHALL return to IDLE with out_valid=0 and out_bit=0 after a word's final bit if no handshake occurred.
REQ-020 SHALL keep out_bit at 0 whenever out_valid is 0.
REQ-021 SHALL use a bit-index counter of width $clog2(DATA_W+1) that counts 0..DATA_W-1 and never wraps mid-word.
REQ-022 SHALL increment word_cnt by 1 on the cycle after the final bit of a word, wrapping modulo 2^CNT_W.
REQ-023 SHALL, on soft_clr high at an edge, force IDLE, out_valid=0 and out_bit=0, discard the word in flight without counting it, and leave word_cnt unchanged.
REQ-024 SHALL give soft_clr priority over a simultaneous handshake, so no word is accepted in that cycle.

Reset
REQ-025 SHALL, while reset is low, asynchronously force state=IDLE, out_bit=0, out_valid=0, word_cnt=0 and clear the shift register and bit index.
REQ-026 SHALL, when reset asserts mid-word, drop the remaining bits immediately; the first handshake is possible on the first edge after reset deasserts.

Configuration
REQ-027 SHALL, with SER_PARITY_EN defined, append after the last payload bit one even-parity bit (XOR of the DATA_W payload bits) with out_valid=1, giving DATA_W+1 cycles per word.
REQ-028 SHALL, without SER_PARITY_EN, contain no PARITY state or parity logic, giving DATA_W cycles per word.

Structure
REQ-029 SHALL place the state enum type (IDLE/SHIFT/PARITY encoding) in shared package serial_pkg for reuse by the detector bench.
REQ-030 SHALL place constants SER_DATA_W_DEF=8 and SER_CNT_W_DEF=16 in serial_pkg.
REQ-031 SHALL implement the shifter as one sub-module, ser_shift_reg, which loads, shifts in either direction and presents the current bit; the FSM, handshake and counter stay in the top level.

Verification
REQ-032 SHALL verify, without parity: 0xB0, msb_first=1, single word -> out_bit 1,0,1,1,0,0,0,0 over 8 cycles starting 1 cycle after handshake, then out_valid=0 and word_cnt=1.
REQ-033 SHALL verify: 0x0D, msb_first=0 -> out_bit 1,0,1,1,0,0,0,0, showing LSB-first order.
REQ-034 SHALL verify: 0xFF then 0x00 back-to-back with data_valid held -> 16 consecutive out_valid cycles, data_ready high only in cycles 0 and 8, and word_cnt=2.
REQ-035 SHALL verify: soft_clr in the 4th bit of 0xAA -> out_valid=0 on the next cycle, word_cnt unchanged, and the next word 0x0F serialised intact.
REQ-036 SHALL verify: reset low for 1 cycle mid-word -> outputs zero at once, word_cnt=0, and a fresh handshake accepted on the first edge after release.
REQ-037 SHALL verify, with SER_PARITY_EN: 0xB0 -> 8 payload bits then parity bit 1, 9 valid cycles; 0x03 -> parity bit 0.

Source files
------------

// File: rtl/serial_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serial_pkg : shared state encoding and default widths for the serial   |
// | link; SER_PARITY_EN adds the PARITY state.   Rev 1.0                   |
// +-----------------------------------------------------------------------+
package serial_pkg;

  localparam int SER_DATA_W_DEF = 8;
  localparam int SER_CNT_W_DEF  = 16;

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } ser_state_e;
`endif

endpackage
`default_nettype wire

// File: rtl/ser_shift_reg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ser_shift_reg : bidirectional shifter; presents the first bit of the   |
// | word being loaded and the next pending bit of the word in flight.      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module ser_shift_reg
  import serial_pkg::*;
#(
  parameter int DATA_W = SER_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_msb_first,
  output logic              o_first_bit,
  output logic              o_cur_bit
);

  logic [DATA_W-1:0] r_sreg;
  logic              r_msb_first;

  function automatic logic [DATA_W-1:0] f_shift(input logic [DATA_W-1:0] v,
                                                input logic              msb);
    return msb ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  // The first bit leaves straight from i_data, so the register holds the
  // word pre-shifted and its output end is always the next bit to send.
  assign o_first_bit = i_msb_first ? i_data[DATA_W-1] : i_data[0];
  assign o_cur_bit   = r_msb_first ? r_sreg[DATA_W-1] : r_sreg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg      <= '0;
      r_msb_first <= 1'b0;
    end else if (i_clr) begin
      r_sreg      <= '0;
      r_msb_first <= 1'b0;
    end else if (i_load) begin
      r_sreg      <= f_shift(i_data, i_msb_first);
      r_msb_first <= i_msb_first;
    end else if (i_shift) begin
      r_sreg      <= f_shift(r_sreg, r_msb_first);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bit_serializer : parallel-to-serial converter with valid/ready input,  |
// | zero-gap word chaining and a completed-word counter.                   |
// | Optional macro SER_PARITY_EN appends an even-parity bit.   Rev 1.0     |
// +-----------------------------------------------------------------------+
module bit_serializer
  import serial_pkg::*;
#(
  parameter int DATA_W = SER_DATA_W_DEF,
  parameter int CNT_W  = SER_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              msb_first,
  input  logic              soft_clr,
  output logic              out_bit,
  output logic              out_valid,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int                 c_IDX_W    = $clog2(DATA_W + 1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_W - 1);

  ser_state_e         r_state;
  logic [c_IDX_W-1:0] r_idx;
  logic               r_out_bit;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_word_cnt;

  logic w_last_payload;
  logic w_final;
  logic w_hs;
  logic w_first_bit;
  logic w_cur_bit;

  assign w_last_payload = (r_state == SHIFT) && (r_idx == c_LAST_IDX);

`ifdef SER_PARITY_EN
  logic r_parity;
  assign w_final = (r_state == PARITY);
`else
  assign w_final = w_last_payload;
`endif

  assign data_ready = !soft_clr && ((r_state == IDLE) || w_final);
  assign w_hs       = data_valid && data_ready;

  ser_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk         (clk),
    .rst_n       (reset),
    .i_clr       (soft_clr),
    .i_load      (w_hs),
    .i_shift     (r_state == SHIFT),
    .i_data      (data_in),
    .i_msb_first (msb_first),
    .o_first_bit (w_first_bit),
    .o_cur_bit   (w_cur_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_word_cnt  <= '0;
`ifdef SER_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      if (w_final && !soft_clr) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end

      if (soft_clr) begin
        r_state     <= IDLE;
        r_idx       <= '0;
        r_out_bit   <= 1'b0;
        r_out_valid <= 1'b0;
      end else if (w_hs) begin
        r_state     <= SHIFT;
        r_idx       <= '0;
        r_out_bit   <= w_first_bit;
        r_out_valid <= 1'b1;
`ifdef SER_PARITY_EN
        r_parity    <= ^data_in;
`endif
      end else begin
        case (r_state)
          SHIFT: begin
            if (w_last_payload) begin
              r_idx       <= '0;
`ifdef SER_PARITY_EN
              r_state     <= PARITY;
              r_out_bit   <= r_parity;
              r_out_valid <= 1'b1;
`else
              r_state     <= IDLE;
              r_out_bit   <= 1'b0;
              r_out_valid <= 1'b0;
`endif
            end else begin
              r_idx       <= r_idx + c_IDX_W'(1);
              r_out_bit   <= w_cur_bit;
              r_out_valid <= 1'b1;
            end
          end
`ifdef SER_PARITY_EN
          PARITY: begin
            r_state     <= IDLE;
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
          end
`endif
          default: begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_bit   = r_out_bit;
  assign out_valid = r_out_valid;
  assign word_cnt  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// tb_bit_serializer : table-driven vectors plus hand-written corner sequences;
// expected serial bits flow through a scoreboard queue.
module tb_bit_serializer;

`ifdef SER_PARITY_EN
  localparam int WC  = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int WC  = 8;
  localparam bit PAR = 1'b0;
`endif

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic [7:0]  data_in    = '0;
  logic        data_valid = 1'b0;
  logic        msb_first  = 1'b0;
  logic        soft_clr   = 1'b0;
  logic        data_ready;
  logic        out_bit;
  logic        out_valid;
  logic [15:0] word_cnt;

  int   n_cmp   = 0;
  int   n_err   = 0;
  int   exp_cnt = 0;
  logic exp_q[$];

  // stream[8:1] = payload bits in wire order, stream[0] = even parity
  typedef struct {
    logic [7:0] data;
    logic       msb;
    logic [8:0] stream;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  bit_serializer #(
    .DATA_W (8),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .msb_first  (msb_first),
    .soft_clr   (soft_clr),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .word_cnt   (word_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_stream(input logic [8:0] s);
    for (int i = 8; i >= 1; i--) exp_q.push_back(s[i]);
    if (PAR) exp_q.push_back(s[0]);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_bit: got out_valid=1 expected no bit at %0t", $time);
      end else begin
        check("serial_bit", out_bit, exp_q.pop_front());
      end
    end else begin
      check("idle_bit_zero", out_bit, 1'b0);
    end
  end

  task automatic send(input logic [7:0] d, input logic m, input logic [8:0] s);
    int budget = 50;
    data_in    = d;
    msb_first  = m;
    data_valid = 1'b1;
    @(negedge clk);
    while (!data_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("ready_before_hs", data_ready, 1'b1);
    push_stream(s);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    check("latency1_valid", out_valid, 1'b1);
  endtask

  task automatic end_of_word(input string tag);
    check({tag, "_valid_low"}, out_valid, 1'b0);
    check({tag, "_word_cnt"}, word_cnt, exp_cnt);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hB0, 1'b1, 9'b10110000_1};
    vecs[1] = '{8'h0D, 1'b0, 9'b10110000_1};
    vecs[2] = '{8'h03, 1'b1, 9'b00000011_0};
    vecs[3] = '{8'hA5, 1'b0, 9'b10100101_0};
    vecs[4] = '{8'h5C, 1'b1, 9'b01011100_0};
    vecs[5] = '{8'h81, 1'b0, 9'b10000001_0};
    vecs[6] = '{8'h37, 1'b0, 9'b11101100_1};

    // reset state
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_bit", out_bit, 1'b0);
    check("rst_word_cnt", word_cnt, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_in_idle", data_ready, 1'b1);

    // single words with idle gaps
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].data, vecs[i].msb, vecs[i].stream);
      repeat (WC) @(posedge clk);
      #1;
      exp_cnt++;
      end_of_word("single");
    end

    // back-to-back 0xFF then 0x00 with data_valid held
    data_in    = 8'hFF;
    msb_first  = 1'b1;
    data_valid = 1'b1;
    for (int c = 0; c <= 2 * WC; c++) begin
      @(negedge clk);
      check("b2b_ready", data_ready, (c == 0 || c == WC || c == 2 * WC));
      check("b2b_valid", out_valid, (c >= 1));
      if (c == 0)  push_stream(9'b11111111_0);
      if (c == WC) push_stream(9'b00000000_0);
      @(posedge clk);
      #1;
      if (c == 0)  data_in = 8'h00;
      if (c == WC) data_valid = 1'b0;
    end
    exp_cnt += 2;
    end_of_word("b2b");

    // soft_clr during the 4th bit of 0xAA
    send(8'hAA, 1'b1, 9'b10101010_0);
    repeat (3) @(posedge clk);
    #1;
    soft_clr = 1'b1;
    #1;
    check("clr_ready_low", data_ready, 1'b0);
    @(posedge clk);
    #1;
    soft_clr = 1'b0;
    check("clr_valid_low", out_valid, 1'b0);
    check("clr_bit_low", out_bit, 1'b0);
    check("clr_word_cnt", word_cnt, exp_cnt);
    exp_q.delete();

    // soft_clr beats a simultaneous handshake
    data_in    = 8'h0F;
    msb_first  = 1'b1;
    data_valid = 1'b1;
    soft_clr   = 1'b1;
    #1;
    check("prio_ready_low", data_ready, 1'b0);
    @(posedge clk);
    #1;
    soft_clr   = 1'b0;
    data_valid = 1'b0;
    check("prio_no_accept", out_valid, 1'b0);

    send(8'h0F, 1'b1, 9'b00001111_0);
    repeat (WC) @(posedge clk);
    #1;
    exp_cnt++;
    end_of_word("after_clr");

    // asynchronous reset mid-word, then handshake on the first edge after release
    send(8'h5C, 1'b1, 9'b01011100_0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid_low", out_valid, 1'b0);
    check("arst_bit_low", out_bit, 1'b0);
    check("arst_word_cnt", word_cnt, 16'd0);
    exp_q.delete();
    exp_cnt    = 0;
    data_in    = 8'h81;
    msb_first  = 1'b0;
    data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_ready", data_ready, 1'b1);
    push_stream(9'b10000001_0);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    check("post_rst_accept", out_valid, 1'b1);
    repeat (WC) @(posedge clk);
    #1;
    exp_cnt++;
    end_of_word("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
